// File: rtl/pipeline_run_ctrl_pkg.sv
// ============================================================================
// Module      : pipeline_run_ctrl_pkg
// Description : Shared types and constants for the pipeline run-control block.
//               - run_state_t : run-control FSM state encoding (3 bits, debug
//                               visible on run_state)
//               - run_dec_t   : outcome of the RUN-state priority decision
//               - run_decide  : priority encoder
//                               ext_stall > trap_mem > hazard_lu > branch_taken
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_run_ctrl_pkg;

  localparam int RUN_STATE_W = 3;

  typedef enum logic [RUN_STATE_W-1:0] {
    S_INIT   = 3'd0,
    S_RUN    = 3'd1,
    S_XSTALL = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALT   = 3'd4
  } run_state_t;

  typedef enum logic [2:0] {
    DEC_NONE   = 3'd0,
    DEC_XSTALL = 3'd1,
    DEC_TRAP   = 3'd2,
    DEC_HAZARD = 3'd3,
    DEC_BRANCH = 3'd4
  } run_dec_t;

  // Single point of truth for event priority in RUN (and in XSTALL once the
  // external stall is released, which behaves exactly like RUN).
  function automatic run_dec_t run_decide(input logic ext_stall,
                                          input logic trap_mem,
                                          input logic hazard_lu,
                                          input logic branch_taken);
    run_dec_t dec;
    if (ext_stall)         dec = DEC_XSTALL;
    else if (trap_mem)     dec = DEC_TRAP;
    else if (hazard_lu)    dec = DEC_HAZARD;
    else if (branch_taken) dec = DEC_BRANCH;
    else                   dec = DEC_NONE;
    return dec;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_run_ctrl_if.sv
// ============================================================================
// Module      : pipeline_run_ctrl_if
// Description : Bundle between the run controller and the 5-stage pipeline.
//               Events from the pipeline : ext_stall, hazard_lu, branch_taken,
//                                          trap_mem, wb_valid
//               Controls to the pipeline : pc_en, if_id_en, id_ex_en,
//                                          ex_mem_en, mem_wb_en, if_id_flush,
//                                          id_ex_flush, halted
//               Debug / performance      : run_state, cycle_cnt, stall_cnt,
//                                          retire_cnt
//               modport master : the run controller
//               modport slave  : the pipeline / debug side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_run_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_run_ctrl_pkg::*;

  logic                   ext_stall;
  logic                   hazard_lu;
  logic                   branch_taken;
  logic                   trap_mem;
  logic                   wb_valid;

  logic                   pc_en;
  logic                   if_id_en;
  logic                   id_ex_en;
  logic                   ex_mem_en;
  logic                   mem_wb_en;
  logic                   if_id_flush;
  logic                   id_ex_flush;
  logic                   halted;
  logic [RUN_STATE_W-1:0] run_state;
  logic [CNT_W-1:0]       cycle_cnt;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       retire_cnt;

  modport master (
    input  ext_stall, hazard_lu, branch_taken, trap_mem, wb_valid,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, halted, run_state,
    output cycle_cnt, stall_cnt, retire_cnt
  );

  modport slave (
    output ext_stall, hazard_lu, branch_taken, trap_mem, wb_valid,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, halted, run_state,
    input  cycle_cnt, stall_cnt, retire_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : W-bit up-counter that sticks at all-ones instead of wrapping.
//               clk   in  clock, rising edge
//               reset in  asynchronous active-high clear
//               inc   in  count enable
//               clr   in  synchronous clear (wins over inc)
//               q     out counter value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         inc,
  input  wire logic         clr,
  output logic      [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
// ============================================================================
// Module      : pipeline_run_ctrl
// Description : Run-control and stall/flush sequencer for the 5-stage
//               IF/ID/EX/MEM/WB pipeline. Merges external stall, load-use
//               hazard, taken branch and MEM-stage trap into per-stage
//               enables and flushes; drains on trap and parks in HALT.
//               clk   in  pipeline clock, rising edge
//               reset in  asynchronous active-high, clears all state
//               bus   pipeline_run_ctrl_if.master (events in, controls out)
//               Optional feature macro: PIPE_PERF_CNT_EN
//                 defined   -> cycle/stall/retire saturating counters
//                 undefined -> the three counter outputs are tied to zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  pipeline_run_ctrl_if.master bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

  run_state_t         state_q, state_d;
  logic [DRAIN_W-1:0] drain_ctr_q, drain_ctr_d;

  run_dec_t dec;
  logic     pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic     if_id_flush, id_ex_flush, halted;

  always_comb begin
    state_d     = state_q;
    drain_ctr_d = drain_ctr_q;
    dec         = DEC_NONE;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      S_INIT: begin
        // Bubble both front latches so nothing stale survives reset.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = S_RUN;
      end

      // XSTALL with the stall released is indistinguishable from RUN, so the
      // pipe restarts in the same cycle the request drops.
      S_RUN, S_XSTALL: begin
        dec = run_decide(bus.ext_stall, bus.trap_mem, bus.hazard_lu,
                         bus.branch_taken);
        unique case (dec)
          DEC_XSTALL: begin
            state_d = S_XSTALL;
          end
          DEC_TRAP: begin
            // Let the trapping instruction move into WB; kill what follows it.
            mem_wb_en   = 1'b1;
            id_ex_flush = 1'b1;
            drain_ctr_d = DRAIN_INIT;
            state_d     = S_DRAIN;
          end
          DEC_HAZARD: begin
            // Hold PC and IF/ID, inject a bubble into EX; branch is moot
            // because the consumer in ID is replayed next cycle.
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = S_RUN;
          end
          DEC_BRANCH: begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            if_id_flush = 1'b1;
            state_d     = S_RUN;
          end
          default: begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            state_d   = S_RUN;
          end
        endcase
      end

      S_DRAIN: begin
        // External freeze also pauses the drain count.
        if (!bus.ext_stall) begin
          mem_wb_en = 1'b1;
          if (drain_ctr_q == DRAIN_LAST) begin
            state_d = S_HALT;
          end else begin
            drain_ctr_d = drain_ctr_q - DRAIN_LAST;
          end
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      drain_ctr_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_ctr_q <= drain_ctr_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.halted      = halted;
  assign bus.run_state   = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic cycle_inc, stall_inc, retire_inc;

  assign cycle_inc  = (state_q == S_RUN) || (state_q == S_XSTALL) ||
                      (state_q == S_DRAIN);
  assign stall_inc  = ((state_q == S_RUN) || (state_q == S_XSTALL)) && !pc_en;
  assign retire_inc = bus.wb_valid && (state_q != S_HALT);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cycle_inc),
    .clr   (1'b0),
    .q     (bus.cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (1'b0),
    .q     (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_inc),
    .clr   (1'b0),
    .q     (bus.retire_cnt)
  );
`else
  // wb_valid only feeds the retire counter.
  logic unused_wb_valid;
  assign unused_wb_valid = bus.wb_valid;

  assign bus.cycle_cnt  = {CNT_W{1'b0}};
  assign bus.stall_cnt  = {CNT_W{1'b0}};
  assign bus.retire_cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_run_ctrl
// Description : Self-checking bench for pipeline_run_ctrl. A 32-bit-counter
//               instance is checked for outputs/state/counters; a 4-bit-counter
//               instance on the same stimulus shows counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_run_ctrl;
  import pipeline_run_ctrl_pkg::*;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, halted}
  localparam logic [7:0] O_INIT  = 8'b00000_11_0;
  localparam logic [7:0] O_ALL   = 8'b11111_00_0;
  localparam logic [7:0] O_STOP  = 8'b00000_00_0;
  localparam logic [7:0] O_HAZ   = 8'b00111_01_0;
  localparam logic [7:0] O_BR    = 8'b11111_10_0;
  localparam logic [7:0] O_TRAP  = 8'b00001_01_0;
  localparam logic [7:0] O_DRAIN = 8'b00001_00_0;
  localparam logic [7:0] O_HALT  = 8'b00000_00_1;

  logic clk = 1'b0;
  logic reset;
  logic ext, haz, br, trap, wb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_run_ctrl_if #(.CNT_W(32)) bus ();
  pipeline_run_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus.ext_stall     = ext;
  assign bus.hazard_lu     = haz;
  assign bus.branch_taken  = br;
  assign bus.trap_mem      = trap;
  assign bus.wb_valid      = wb;
  assign bus4.ext_stall    = ext;
  assign bus4.hazard_lu    = haz;
  assign bus4.branch_taken = br;
  assign bus4.trap_mem     = trap;
  assign bus4.wb_valid     = wb;

  pipeline_run_ctrl #(.CNT_W(32), .DRAIN_CYCLES(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipeline_run_ctrl #(.CNT_W(4), .DRAIN_CYCLES(1)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct {
    logic       e, h, b;
    logic [7:0] exp_o;
    logic [2:0] exp_s;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [7:0] outs();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
            bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush, bus.halted};
  endfunction

  // Expected counter value for a W-bit saturating counter.
  function automatic logic [31:0] ecnt(input int v, input int w);
    int r;
    r = (w == 4 && v > 15) ? 15 : v;
`ifndef PIPE_PERF_CNT_EN
    r = 0;
`endif
    return 32'(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int c, input int s, input int r);
    chk({tag, "_cycle"},   bus.cycle_cnt,  ecnt(c, 32));
    chk({tag, "_stall"},   bus.stall_cnt,  ecnt(s, 32));
    chk({tag, "_retire"},  bus.retire_cnt, ecnt(r, 32));
    chk({tag, "_cycle4"},  32'(bus4.cycle_cnt),  ecnt(c, 4));
    chk({tag, "_stall4"},  32'(bus4.stall_cnt),  ecnt(s, 4));
    chk({tag, "_retire4"}, 32'(bus4.retire_cnt), ecnt(r, 4));
  endtask

  task automatic set_in(input logic e, input logic h, input logic b,
                        input logic t, input logic w);
    ext = e; haz = h; br = b; trap = t; wb = w;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, O_ALL,  3'd1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, O_HAZ,  3'd1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, O_HAZ,  3'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, O_BR,   3'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, O_STOP, 3'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, O_STOP, 3'd2};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, O_BR,   3'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, O_ALL,  3'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, O_STOP, 3'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, O_HAZ,  3'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b0, O_ALL,  3'd1};

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // INIT cycle after reset release
    @(negedge clk);
    chk("init_outs",  32'(outs()), 32'(O_INIT));
    chk("init_state", 32'(bus.run_state), 32'd0);
    chk_cnt("init", 0, 0, 0);
    next_cyc();

    // Single-cycle RUN/XSTALL decisions; wb_valid held high throughout.
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].e, tbl[i].h, tbl[i].b, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i),  32'(outs()), 32'(tbl[i].exp_o));
      chk($sformatf("vec%0d_state", i), 32'(bus.run_state), 32'(tbl[i].exp_s));
      next_cyc();
    end
    // 11 counted cycles, pc_en low in vectors 1,2,4,5,8,9, wb in all 11
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    chk_cnt("table", 11, 6, 11);
    next_cyc();                                   // cycle=12

    // Long external stall
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk($sformatf("xstall%0d_outs", i), 32'(outs()), 32'(O_STOP));
      next_cyc();
    end
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("xrel_outs",  32'(outs()), 32'(O_ALL));
    chk("xrel_state", 32'(bus.run_state), 32'd2);
    chk_cnt("xstall", 62, 56, 11);
    next_cyc();                                   // cycle=63

    // One-cycle load-use hazard
    set_in(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("haz_outs", 32'(outs()), 32'(O_HAZ));
    next_cyc();
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("haz_state", 32'(bus.run_state), 32'd1);
    chk_cnt("haz", 64, 57, 11);
    next_cyc();                                   // cycle=65

    // Trap arriving under external stall is deferred to release
    set_in(1, 0, 0, 1, 1);
    @(negedge clk);
    chk("tx0_outs", 32'(outs()), 32'(O_STOP));
    next_cyc();
    @(negedge clk);
    chk("tx1_outs",  32'(outs()), 32'(O_STOP));
    chk("tx1_state", 32'(bus.run_state), 32'd2);
    next_cyc();
    set_in(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("trap_outs", 32'(outs()), 32'(O_TRAP));
    next_cyc();
    set_in(0, 1, 1, 0, 1);
    @(negedge clk);
    chk("drain_outs",  32'(outs()), 32'(O_DRAIN));
    chk("drain_state", 32'(bus.run_state), 32'd3);
    next_cyc();
    set_in(0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("halt%0d_outs", i),  32'(outs()), 32'(O_HALT));
      chk($sformatf("halt%0d_state", i), 32'(bus.run_state), 32'd4);
      chk_cnt($sformatf("halt%0d", i), 69, 60, 15);
      next_cyc();
    end

    // Reset from HALT clears everything immediately
    set_in(0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rsth_state", 32'(bus.run_state), 32'd0);
    chk("rsth_halt",  32'(bus.halted), 32'd0);
    chk_cnt("rsth", 0, 0, 0);
    next_cyc();
    reset = 1'b0;
    next_cyc();                                   // INIT -> RUN

    // Trap straight from RUN, then freeze the drain and reset mid-drain
    set_in(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("trap2_outs", 32'(outs()), 32'(O_TRAP));
    next_cyc();
    set_in(1, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("dfrz%0d_outs", i),  32'(outs()), 32'(O_STOP));
      chk($sformatf("dfrz%0d_state", i), 32'(bus.run_state), 32'd3);
      next_cyc();
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rstd_state", 32'(bus.run_state), 32'd0);
    chk("rstd_halt",  32'(bus.halted), 32'd0);
    chk("rstd_outs",  32'(outs()), 32'(O_INIT));
    chk_cnt("rstd", 0, 0, 0);
    next_cyc();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0);
    next_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
